// File: rtl/led_seq_if.sv
// Avalon-MM slave bus bundle for the LED sequencer register file.
// The master drives address/strobes/data; the slave returns same-cycle read data.
interface led_seq_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps out_port through PATTERN[0..LEN-1], holding each for DWELL cycles.
// When idle, out_port follows the MANUAL register, so the block doubles as a plain LED port.
module led_seq_ctrl #(
    parameter int         DWELL_W      = 24,
    parameter logic [7:0] RESET_MANUAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    led_seq_if.slave   bus,
    output logic [7:0] out_port,
    output logic       busy
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [7:0]         manual_q;
    logic               loop_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         len_q;
    logic [7:0]         pattern_q [0:7];

    logic               wr, start_wr, stop_wr, status_wr;
    logic [DWELL_W-1:0] eff_dwell;
    logic [3:0]         eff_len;
    logic               step_end, last_step;
    logic [7:0]         manual_d, pat_d, out_d;
    logic               busy_d;
    logic               unused_wdata;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign start_wr  = wr && (bus.address == 4'd1) && bus.writedata[0];
    assign stop_wr   = wr && (bus.address == 4'd1) && bus.writedata[2];
    assign status_wr = wr && (bus.address == 4'd4);
    assign unused_wdata = ^bus.writedata;

    // Raw registers are kept as written; clamping happens only here, at use.
    assign eff_dwell = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign eff_len   = (len_q == 4'd0) ? 4'd1 : ((len_q > 4'd8) ? 4'd8 : len_q);
    assign step_end  = (cnt_q >= eff_dwell - DWELL_W'(1));
    assign last_step = ({1'b0, idx_q} >= eff_len - 4'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            out_port <= RESET_MANUAL;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            out_port <= out_d;
            busy     <= busy_d;
        end
    end

    // STOP has priority over START; DONE set has priority over a STATUS clear.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (status_wr)
            done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_wr && !stop_wr) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stop_wr) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (start_wr) begin
                    idx_d = '0;
                    cnt_d = '0;
                end else if (step_end) begin
                    cnt_d = '0;
                    if (!last_step) begin
                        idx_d = idx_q + 3'd1;
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // out_port is registered from next-cycle values so writes show up right after their edge.
    always_comb begin
        manual_d = (wr && bus.address == 4'd0) ? bus.writedata[7:0] : manual_q;
        pat_d    = (wr && bus.address == {1'b1, idx_d}) ? bus.writedata[7:0] : pattern_q[idx_d];
        out_d    = (state_d == RUN) ? pat_d : manual_d;
        busy_d   = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            manual_q <= RESET_MANUAL;
            loop_q   <= 1'b0;
            dwell_q  <= DWELL_W'(1);
            len_q    <= 4'd1;
            for (int i = 0; i < 8; i++)
                pattern_q[i] <= '0;
        end else if (wr) begin
            case (bus.address)
                4'd0: manual_q <= bus.writedata[7:0];
                4'd1: loop_q   <= bus.writedata[1];
                4'd2: dwell_q  <= bus.writedata[DWELL_W-1:0];
                4'd3: len_q    <= bus.writedata[3:0];
                default: begin
                    if (bus.address[3])
                        pattern_q[bus.address[2:0]] <= bus.writedata[7:0];
                end
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            4'd0: bus.readdata[7:0] = manual_q;
            4'd1: bus.readdata[1] = loop_q;
            4'd2: bus.readdata[DWELL_W-1:0] = dwell_q;
            4'd3: bus.readdata[3:0] = len_q;
            4'd4: begin
                bus.readdata[0]   = busy;
                bus.readdata[6:4] = idx_q;
                bus.readdata[8]   = done_q;
            end
            default: begin
                if (bus.address[3])
                    bus.readdata[7:0] = pattern_q[bus.address[2:0]];
            end
        endcase
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: register access, one-shot/loop sequencing, clamping and reset.
module tb_led_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] out_port;
    logic       busy;
    int         n_checks = 0;
    int         n_fail   = 0;

    led_seq_if bus();

    led_seq_ctrl #(.DWELL_W(24), .RESET_MANUAL(8'h00)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Tasks start and end 1ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    task automatic check_rd(input string tag, input logic [3:0] addr, input logic [31:0] mask,
                            input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(addr, d);
        check(tag, d & mask, exp);
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_out, input logic exp_busy);
        check({tag, "_out"}, 32'(out_port), 32'(exp_out));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        logic [7:0] exp8;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset_n        = 1'b0;
        #12;
        check_out("rst", 8'h00, 1'b0);
        check_rd("rst_manual", 4'd0, 32'hFFFF_FFFF, 32'h0);
        check_rd("rst_dwell", 4'd2, 32'hFFFF_FFFF, 32'h1);
        check_rd("rst_len", 4'd3, 32'hFFFF_FFFF, 32'h1);
        check_rd("rst_status", 4'd4, 32'hFFFF_FFFF, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1);

        // Manual mode
        bus_wr(4'd0, 32'h0000_00A5);
        check_out("manual", 8'hA5, 1'b0);
        check_rd("manual_rd", 4'd0, 32'hFFFF_FFFF, 32'h0000_00A5);
        check_rd("unmapped_rd", 4'd6, 32'hFFFF_FFFF, 32'h0);

        // One-shot: 3 steps x 4 cycles
        bus_wr(4'd8, 32'h01);
        bus_wr(4'd9, 32'h02);
        bus_wr(4'd10, 32'h04);
        bus_wr(4'd3, 32'd3);
        bus_wr(4'd2, 32'd4);
        bus_wr(4'd1, 32'h1);
        for (int i = 0; i < 12; i++) begin
            exp8 = (i < 4) ? 8'h01 : ((i < 8) ? 8'h02 : 8'h04);
            check_out("oneshot", exp8, 1'b1);
            if (i == 4) check_rd("oneshot_idx", 4'd4, 32'h171, 32'h011);
            if (i == 11) check_rd("oneshot_notdone", 4'd4, 32'h100, 32'h0);
            tick(1);
        end
        check_out("oneshot_end", 8'hA5, 1'b0);
        check_rd("oneshot_done", 4'd4, 32'h101, 32'h100);
        check_rd("ctrl_pulse_rd", 4'd1, 32'hFFFF_FFFF, 32'h0);
        bus_wr(4'd4, 32'h0);
        check_rd("done_clr", 4'd4, 32'h100, 32'h0);

        // Loop then stop
        bus_wr(4'd1, 32'h2);
        bus_wr(4'd3, 32'd2);
        bus_wr(4'd2, 32'd1);
        bus_wr(4'd1, 32'h3);
        for (int i = 0; i < 6; i++) begin
            check_out("loop", (i % 2 == 0) ? 8'h01 : 8'h02, 1'b1);
            tick(1);
        end
        bus_wr(4'd1, 32'h6);
        check_out("stop", 8'hA5, 1'b0);
        check_rd("stop_nodone", 4'd4, 32'h101, 32'h0);
        check_rd("loop_rd", 4'd1, 32'hFFFF_FFFF, 32'h2);

        // Clamp: LEN=0, DWELL=0 gives a single 1-cycle step
        bus_wr(4'd1, 32'h0);
        bus_wr(4'd3, 32'd0);
        bus_wr(4'd2, 32'd0);
        bus_wr(4'd1, 32'h1);
        check_out("clamp0", 8'h01, 1'b1);
        tick(1);
        check_out("clamp0_end", 8'hA5, 1'b0);
        check_rd("clamp0_done", 4'd4, 32'h100, 32'h100);
        check_rd("len_raw0", 4'd3, 32'hFFFF_FFFF, 32'h0);
        bus_wr(4'd4, 32'h0);

        // Clamp: LEN=12 runs 8 steps and wraps 7 -> 0
        bus_wr(4'd11, 32'h08);
        bus_wr(4'd12, 32'h10);
        bus_wr(4'd13, 32'h20);
        bus_wr(4'd14, 32'h40);
        bus_wr(4'd15, 32'h80);
        bus_wr(4'd3, 32'd12);
        bus_wr(4'd2, 32'd1);
        bus_wr(4'd1, 32'h3);
        for (int i = 0; i < 10; i++) begin
            exp8 = 8'h01 << (i % 8);
            check_out("clamp12", exp8, 1'b1);
            tick(1);
        end
        bus_wr(4'd1, 32'h6);
        check_out("clamp12_stop", 8'hA5, 1'b0);
        check_rd("len_raw12", 4'd3, 32'hFFFF_FFFF, 32'd12);
        check_rd("pattern7_rd", 4'd15, 32'hFFFF_FFFF, 32'h80);

        // Mid-run LEN shrink during step index 4 of 8 (DWELL=100)
        bus_wr(4'd1, 32'h0);
        bus_wr(4'd3, 32'd8);
        bus_wr(4'd2, 32'd100);
        bus_wr(4'd1, 32'h1);
        tick(410);
        check_out("mid_step4", 8'h10, 1'b1);
        bus_wr(4'd3, 32'd3);
        check_out("mid_after_wr", 8'h10, 1'b1);
        tick(88);
        check_out("mid_last", 8'h10, 1'b1);
        tick(1);
        check_out("mid_end", 8'hA5, 1'b0);
        check_rd("mid_done", 4'd4, 32'h101, 32'h100);

        // STOP while idle has no effect; START+STOP while running goes idle
        bus_wr(4'd1, 32'h4);
        check_out("stop_idle", 8'hA5, 1'b0);
        check_rd("stop_idle_done", 4'd4, 32'h100, 32'h100);
        bus_wr(4'd3, 32'd2);
        bus_wr(4'd2, 32'd1);
        bus_wr(4'd1, 32'h3);
        tick(3);
        check_out("restart_run", 8'h02, 1'b1);
        bus_wr(4'd1, 32'h7);
        check_out("start_stop", 8'hA5, 1'b0);
        check_rd("start_stop_done", 4'd4, 32'h100, 32'h100);
        bus_wr(4'd4, 32'h0);

        // DONE set in the same cycle as a STATUS write: set wins
        bus_wr(4'd3, 32'd1);
        bus_wr(4'd1, 32'h1);
        bus_wr(4'd4, 32'h0);
        check_out("setwin", 8'hA5, 1'b0);
        check_rd("setwin_done", 4'd4, 32'h100, 32'h100);

        // Asynchronous reset during a looping run
        bus_wr(4'd3, 32'd2);
        bus_wr(4'd1, 32'h3);
        tick(2);
        reset_n = 1'b0;
        #2;
        check_out("rst_mid", 8'h00, 1'b0);
        check_rd("rst_mid_manual", 4'd0, 32'hFFFF_FFFF, 32'h0);
        check_rd("rst_mid_ctrl", 4'd1, 32'hFFFF_FFFF, 32'h0);
        check_rd("rst_mid_dwell", 4'd2, 32'hFFFF_FFFF, 32'h1);
        check_rd("rst_mid_len", 4'd3, 32'hFFFF_FFFF, 32'h1);
        check_rd("rst_mid_status", 4'd4, 32'hFFFF_FFFF, 32'h0);
        check_rd("rst_mid_pat", 4'd9, 32'hFFFF_FFFF, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1);
        check_out("post_rst", 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Avalon-MM slave controller that sequences an 8-bit LED output port through a programmable pattern table. Each step is held for a programmable dwell time, in one-shot or looping mode. When idle, a manual register drives the port, so the block also works as a plain LED output register. It sits on the SoC system bus with zero-wait-state, same-cycle read data and drives board LEDs directly.

## Interface
Parameters:
- DWELL_W, 24, width of dwell counter/register
- RESET_MANUAL, 8'h00, reset value of MANUAL register

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  4  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, unused bits 0
- out_port  out  8  LED drive
- busy  out  1  sequence running

## Operation
Register map (word address):
- 0 MANUAL rw [7:0]: drives out_port when idle.
- 1 CTRL: bit0 START (write-1 pulse, reads 0), bit1 LOOP (rw), bit2 STOP (write-1 pulse, reads 0).
- 2 DWELL rw [DWELL_W-1:0]: cycles per step; 0 treated as 1.
- 3 LEN rw [3:0]: steps 1..8; 0 treated as 1, 9..15 clamped to 8. The register stores the raw value; clamping applies only on use.
- 4 STATUS: [0] busy, [6:4] current index, [8] DONE sticky. Any write to address 4 clears DONE.
- 8..15 PATTERN[0..7] rw [7:0].
- Other addresses: read 0, writes ignored.

A write occurs when chipselect=1 and write_n=0. readdata follows address regardless of chipselect.

State machine:
- IDLE: out_port=MANUAL, busy=0.
  - START → RUN, idx=0, cnt=0.
- RUN: out_port=PATTERN[idx], busy=1. cnt increments each cycle. When cnt ≥ eff_DWELL−1, the step ends and cnt=0:
  - idx < eff_LEN−1: idx+1.
  - idx ≥ eff_LEN−1 and LOOP=1: idx=0.
  - idx ≥ eff_LEN−1 and LOOP=0: → IDLE, DONE=1.
  - STOP → IDLE, DONE unchanged.
  - START while in RUN restarts: idx=0, cnt=0.

Boundary rules:
- START and STOP in the same write: STOP wins.
- A STOP write while IDLE has no effect.
- DWELL, LEN, LOOP and PATTERN writes during RUN take effect at the next comparison or display. Use ≥ comparisons so that shrinking DWELL or LEN never stalls the sequence.
- DONE set and a STATUS write in the same cycle: set wins.
- Reset (any time, including mid-run): state=IDLE, idx=0, cnt=0, MANUAL=RESET_MANUAL, DWELL=1, LEN=1, LOOP=0, DONE=0, PATTERN all 0.
  - out_port=RESET_MANUAL, busy=0, readdata reflects reset registers.

## Timing
- All registers update on posedge clk. Reset acts asynchronously.
- out_port and busy are registered functions of state, idx and registers. A register write at edge N is visible on out_port after edge N.
- START written at edge N: out_port=PATTERN[0] and busy=1 from edge N. Each step lasts exactly eff_DWELL cycles.
- One-shot run length: eff_LEN×eff_DWELL cycles. out_port returns to MANUAL at the same edge that sets DONE.
- STOP at edge N: out_port=MANUAL from edge N.
- Read latency 0: readdata is valid in the same cycle as address.

## Test plan
- Reset mid-run: assert reset_n=0 during a looping run → out_port=8'h00, busy=0, STATUS reads 0, all registers at reset values.
- Manual mode: write MANUAL=8'hA5 → out_port=8'hA5 one cycle later; read addr 0 = 32'h000000A5.
- One-shot: PATTERN[0..2]=01,02,04, LEN=3, DWELL=4, START → out_port 01/02/04 for 4 cycles each, then A5. DONE=1 after 12 cycles; a STATUS write clears DONE.
- Loop + stop: LOOP=1, LEN=2, DWELL=1 → out_port alternates every cycle. A STOP write returns out_port to MANUAL next cycle, with DONE=0.
- Clamping: LEN=0 with DWELL=0 → one step of 1 cycle. LEN=12 → 8 steps, idx wraps 7→0 in loop mode.
- Mid-run changes: during step 5 of 8 with DWELL=100, write LEN=3 → sequence ends (or wraps) at the end of the current step. START plus STOP in the same write → IDLE.
